// File: rtl/uart_pkg.sv
// Shared types and constants for the UART controller.
// Contents: TX/RX state enums, oversampling constants.
// Imported by uart_ctrl; no logic lives here.
package uart_pkg;

  // Ticks per bit period, and the tick at which the start bit is re-checked.
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer: synchronous FIFO holding {data, parity_err, frame_err} entries.
// Ports: push/push_data in, pop/pop_data (head, 0-cycle read) out, empty, level, overrun pulse.
// Backpressure: a push into a full FIFO is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];
  assign level    = count;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overrun <= push && !do_push;
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// UART controller: 16x oversampled transmitter and receiver with a receive FIFO.
// Ports: rx/tx serial lines, tx valid/ready/data handshake, rx FIFO head (valid/ready/data + flags),
//        rx_overrun pulse, rx_busy/tx_busy, rx_level. Optional parity: define UART_CTRL_PARITY_EN.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_DIV       = 326,
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1,
  parameter int PARITY_ODD    = 0,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rx,
  output logic                           tx,
  input  logic                           tx_valid,
  output logic                           tx_ready,
  input  logic [DATA_BITS-1:0]           tx_data,
  output logic                           rx_valid,
  input  logic                           rx_ready,
  output logic [DATA_BITS-1:0]           rx_data,
  output logic                           rx_frame_err,
  output logic                           rx_parity_err,
  output logic                           rx_overrun,
  output logic                           rx_busy,
  output logic                           tx_busy,
  output logic [$clog2(RX_FIFO_DEPTH):0] rx_level
);

  localparam int              DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]      TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      TICK_MID  = 4'(SAMPLE_MID - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
  localparam int              FW        = DATA_BITS + 2;

  if (DATA_BITS < 5 || DATA_BITS > 8 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1) || RX_FIFO_DEPTH < 2 ||
      (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_ctrl: illegal parameter value");
  end

`ifdef UART_CTRL_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

  // ------------------------------------------------------------------
  // Transmitter
  // ------------------------------------------------------------------
  tx_state_t            tx_state, tx_state_n;
  logic [DIV_W-1:0]     tx_div;
  logic [3:0]           tx_tcnt;
  logic [2:0]           tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_tick;
  logic                 tx_bit_end;
  logic                 tx_load;
  logic                 tx_shift_en;
  logic                 tx_idx_clr;
  logic                 tx_idx_inc;
`ifdef UART_CTRL_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_tick    = (tx_div == DIV_LAST);
  assign tx_bit_end = tx_tick && (tx_tcnt == TICK_LAST);
  assign tx_ready   = (tx_state == TX_IDLE);
  assign tx_busy    = !tx_ready;

  always_comb begin
    tx_state_n  = tx_state;
    tx_load     = 1'b0;
    tx_shift_en = 1'b0;
    tx_idx_clr  = 1'b0;
    tx_idx_inc  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_state_n = TX_START;
          tx_load    = 1'b1;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_n = TX_DATA;
          tx_idx_clr = 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_en = 1'b1;
          if (tx_idx == DATA_LAST) begin
`ifdef UART_CTRL_PARITY_EN
            tx_state_n = TX_PARITY;
`else
            tx_state_n = TX_STOP;
`endif
            tx_idx_clr = 1'b1;
          end else begin
            tx_idx_inc = 1'b1;
          end
        end
      end
`ifdef UART_CTRL_PARITY_EN
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_state_n = TX_STOP;
          tx_idx_clr = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_idx == STOP_LAST) begin
            tx_state_n = TX_IDLE;
          end else begin
            tx_idx_inc = 1'b1;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // Line level is a pure function of registered state, so reset drives it high at once.
  always_comb begin
    tx = 1'b1;
    case (tx_state)
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = tx_shift[0];
`ifdef UART_CTRL_PARITY_EN
      TX_PARITY: tx = tx_par;
`endif
      default:   tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_div   <= '0;
      tx_tcnt  <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
`ifdef UART_CTRL_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      // Counters sit at zero while idle, so the start bit begins a fresh bit period.
      if (tx_state == TX_IDLE) begin
        tx_div  <= '0;
        tx_tcnt <= '0;
      end else if (tx_tick) begin
        tx_div  <= '0;
        tx_tcnt <= tx_tcnt + 1'b1;
      end else begin
        tx_div  <= tx_div + 1'b1;
      end
      if (tx_idx_clr) begin
        tx_idx <= '0;
      end else if (tx_idx_inc) begin
        tx_idx <= tx_idx + 1'b1;
      end
      if (tx_load) begin
        tx_shift <= tx_data;
`ifdef UART_CTRL_PARITY_EN
        tx_par   <= (^tx_data) ^ PAR_ODD;
`endif
      end else if (tx_shift_en) begin
        tx_shift <= tx_shift >> 1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Receiver
  // ------------------------------------------------------------------
  rx_state_t            rx_state, rx_state_n;
  logic                 rx_s1, rx_sync;
  logic [DIV_W-1:0]     rx_div;
  logic [3:0]           rx_tcnt;
  logic [2:0]           rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_tick;
  logic                 rx_mid;
  logic                 rx_sample;
  logic                 rx_tcnt_clr;
  logic                 rx_idx_inc;
  logic                 rx_data_en;
  logic                 rx_stop_en;
  logic                 rx_ferr;
  logic                 rx_perr;
  logic                 rx_push;
  logic                 fifo_empty;
  logic [FW-1:0]        fifo_head;
`ifdef UART_CTRL_PARITY_EN
  logic                 rx_par_en;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_sync <= rx_s1;
    end
  end

  assign rx_tick   = (rx_div == DIV_LAST);
  assign rx_mid    = rx_tick && (rx_tcnt == TICK_MID);
  // After the mid-start re-check the tick counter is cleared, so each later
  // sample lands a full 16 ticks after the previous one.
  assign rx_sample = rx_tick && (rx_tcnt == TICK_LAST);
  assign rx_busy   = (rx_state != RX_IDLE);

  always_comb begin
    rx_state_n  = rx_state;
    rx_tcnt_clr = 1'b0;
    rx_idx_inc  = 1'b0;
    rx_data_en  = 1'b0;
    rx_stop_en  = 1'b0;
`ifdef UART_CTRL_PARITY_EN
    rx_par_en   = 1'b0;
`endif
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_mid) begin
          if (rx_sync) begin
            rx_state_n = RX_IDLE;  // too short to be a start bit
          end else begin
            rx_state_n  = RX_DATA;
            rx_tcnt_clr = 1'b1;
          end
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_data_en = 1'b1;
          if (rx_idx == DATA_LAST) begin
`ifdef UART_CTRL_PARITY_EN
            rx_state_n = RX_PARITY;
`else
            rx_state_n = RX_STOP;
`endif
          end else begin
            rx_idx_inc = 1'b1;
          end
        end
      end
`ifdef UART_CTRL_PARITY_EN
      RX_PARITY: begin
        if (rx_sample) begin
          rx_par_en  = 1'b1;
          rx_state_n = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rx_sample) begin
          rx_stop_en = 1'b1;
          // A low stop may be the front of a break; wait for the line to recover.
          rx_state_n = rx_sync ? RX_IDLE : RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync) begin
          rx_state_n = RX_IDLE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_div   <= '0;
      rx_tcnt  <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_ferr  <= 1'b0;
      rx_push  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      if (rx_state == RX_IDLE || rx_state == RX_WAIT_HIGH) begin
        rx_div  <= '0;
        rx_tcnt <= '0;
        rx_idx  <= '0;
      end else begin
        rx_div <= rx_tick ? '0 : rx_div + 1'b1;
        if (rx_tcnt_clr) begin
          rx_tcnt <= '0;
        end else if (rx_tick) begin
          rx_tcnt <= rx_tcnt + 1'b1;
        end
        if (rx_idx_inc) begin
          rx_idx <= rx_idx + 1'b1;
        end
      end
      if (rx_data_en) begin
        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
      end
      if (rx_stop_en) begin
        rx_ferr <= !rx_sync;
      end
      rx_push <= rx_stop_en;
    end
  end

`ifdef UART_CTRL_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_perr <= 1'b0;
    end else if (rx_par_en) begin
      rx_perr <= rx_sync != ((^rx_shift) ^ PAR_ODD);
    end
  end
`else
  assign rx_perr = 1'b0;
`endif

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data ({rx_shift, rx_perr, rx_ferr}),
    .pop       (rx_ready),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .level     (rx_level),
    .overrun   (rx_overrun)
  );

  assign rx_valid      = !fifo_empty;
  assign rx_data       = fifo_head[FW-1:2];
  // Flags are qualified so an empty FIFO never shows stale or unwritten entries.
  assign rx_parity_err = !fifo_empty && fifo_head[1];
  assign rx_frame_err  = !fifo_empty && fifo_head[0];

endmodule

// File: tb/tb_uart_ctrl.sv
module tb_uart_ctrl;

  localparam int CLK_DIV = 4;
  localparam int BIT     = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  // Main instance: even parity, rx either looped from tx or driven by the bench.
  logic       loop_en, rx_drv, rx_line;
  logic       tx, tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0] tx_data, rx_data;
  logic       rx_frame_err, rx_parity_err, rx_overrun, rx_busy, tx_busy;
  logic [2:0] rx_level;
  assign rx_line = loop_en ? tx : rx_drv;

  // Second instance: odd parity, receive side only.
  logic       o_rx, o_tx, o_tx_ready, o_rx_valid, o_rx_frame_err, o_rx_parity_err;
  logic       o_rx_overrun, o_rx_busy, o_tx_busy;
  logic [7:0] o_rx_data;
  logic [2:0] o_rx_level;
  logic       o_rx_ready = 1'b1;

  uart_ctrl #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0), .RX_FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .rx(rx_line), .tx(tx),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err), .rx_overrun(rx_overrun),
    .rx_busy(rx_busy), .tx_busy(tx_busy), .rx_level(rx_level));

  uart_ctrl #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1), .RX_FIFO_DEPTH(4)) u_odd (
    .clk(clk), .rst(rst), .rx(o_rx), .tx(o_tx),
    .tx_valid(1'b0), .tx_ready(o_tx_ready), .tx_data(8'h00),
    .rx_valid(o_rx_valid), .rx_ready(o_rx_ready), .rx_data(o_rx_data),
    .rx_frame_err(o_rx_frame_err), .rx_parity_err(o_rx_parity_err), .rx_overrun(o_rx_overrun),
    .rx_busy(o_rx_busy), .tx_busy(o_tx_busy), .rx_level(o_rx_level));

  int tests = 0;
  int fails = 0;
  int ovr_cnt = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_odd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every entry the DUTs hand out against the queues.
  always @(negedge clk) begin
    #1;
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rx_unexpected: got entry data=0x%0h perr=%0b ferr=%0b, expected none",
                 rx_data, rx_parity_err, rx_frame_err);
      end else begin
        check("rx_entry", 32'({rx_data, rx_parity_err, rx_frame_err}), 32'(exp_q.pop_front()));
      end
    end
    if (!rst && o_rx_valid && o_rx_ready) begin
      if (exp_odd_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL odd_rx_unexpected: got entry data=0x%0h, expected none", o_rx_data);
      end else begin
        check("odd_rx_entry", 32'({o_rx_data, o_rx_parity_err, o_rx_frame_err}), 32'(exp_odd_q.pop_front()));
      end
    end
    if (!rst && rx_overrun) ovr_cnt++;
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) o_rx = v; else rx_drv = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_rx_frame(input bit sel, input logic [7:0] d, input bit flip, input logic stop_v);
    drive(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive(sel, d[i]);
`ifdef UART_CTRL_PARITY_EN
    drive(sel, (^d) ^ sel ^ flip);
`endif
    drive(sel, stop_v);
  endtask

  task automatic send_tx(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < 2000) begin @(negedge clk); n++; end
    check("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_odd_q.size() != 0) && n < budget) begin @(negedge clk); n++; end
    check({"drain_", name}, 32'(exp_q.size() + exp_odd_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_bits[$];
    int ready_at;
    int nb;
    int exp_ready;
    rst = 1'b1; loop_en = 1'b0; rx_drv = 1'b1; o_rx = 1'b1;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    // Reset state
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_level", 32'(rx_level), 32'd0);
    check("rst_flags", 32'({rx_frame_err, rx_parity_err, rx_overrun}), 32'd0);
    check("rst_rx_busy", 32'(rx_busy), 32'd0);
    check("rst_odd_state", 32'({o_tx, o_tx_ready, o_tx_busy, o_rx_busy, o_rx_overrun, o_rx_level}), 32'b1100_0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // TX waveform of 0xA5
`ifdef UART_CTRL_PARITY_EN
    exp_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    exp_ready = 704;
`else
    exp_bits = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    exp_ready = 640;
`endif
    nb = exp_bits.size();
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_busy_after_xfer", 32'(tx_busy), 32'd1);
    check("tx_start_low", 32'(tx), 32'd0);
    ready_at = -1;
    for (int j = 1; j <= 800 && ready_at < 0; j++) begin
      @(negedge clk);
      if (j % BIT == BIT / 2 && j / BIT < nb)
        check($sformatf("tx_bit%0d", j / BIT), 32'(tx), 32'(exp_bits[j / BIT]));
      if (j == BIT - 1) check("tx_start_last_low", 32'(tx), 32'd0);
      if (j == BIT)     check("tx_bit0_edge", 32'(tx), 32'd1);
      if (tx_ready) ready_at = j;
    end
    check("tx_ready_cycle", 32'(ready_at), 32'(exp_ready));
    check("tx_idle_high", 32'(tx), 32'd1);

    // Loopback
    loop_en = 1'b1;
    exp_q.push_back({8'h00, 2'b00}); send_tx(8'h00);
    exp_q.push_back({8'hFF, 2'b00}); send_tx(8'hFF);
    exp_q.push_back({8'h3C, 2'b00}); send_tx(8'h3C);
    wait_drain("loopback", 3000);
    repeat (BIT) @(negedge clk);
    loop_en = 1'b0;

    // Short low glitch
    rx_drv = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy", 32'(rx_busy), 32'd1);
    repeat (10) @(negedge clk);
    rx_drv = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_idle", 32'(rx_busy), 32'd0);
    check("glitch_level", 32'(rx_level), 32'd0);

    // Frame error followed by a held-low line
    exp_q.push_back({8'h55, 2'b01});
    send_rx_frame(1'b0, 8'h55, 1'b0, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    check("ferr_wait_high_busy", 32'(rx_busy), 32'd1);
    check("ferr_popped", 32'(exp_q.size()), 32'd0);
    check("ferr_no_new_entry", 32'(rx_level), 32'd0);
    drive(1'b0, 1'b1);
    check("ferr_recovered", 32'(rx_busy), 32'd0);
    exp_q.push_back({8'h12, 2'b00});
    send_rx_frame(1'b0, 8'h12, 1'b0, 1'b1);
    drive(1'b0, 1'b1);
    wait_drain("after_ferr", 500);

    // Overrun: five frames into a four-entry FIFO
    rx_ready = 1'b0;
    ovr_cnt = 0;
    send_rx_frame(1'b0, 8'h11, 1'b0, 1'b1); drive(1'b0, 1'b1);
    send_rx_frame(1'b0, 8'h22, 1'b0, 1'b1); drive(1'b0, 1'b1);
    send_rx_frame(1'b0, 8'h33, 1'b0, 1'b1); drive(1'b0, 1'b1);
    send_rx_frame(1'b0, 8'h44, 1'b0, 1'b1); drive(1'b0, 1'b1);
    check("ovr_no_pulse_before_full", 32'(ovr_cnt), 32'd0);
    send_rx_frame(1'b0, 8'h55, 1'b0, 1'b1); drive(1'b0, 1'b1);
    check("ovr_level", 32'(rx_level), 32'd4);
    check("ovr_pulses", 32'(ovr_cnt), 32'd1);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    exp_q.push_back({8'h11, 2'b00});
    exp_q.push_back({8'h22, 2'b00});
    exp_q.push_back({8'h33, 2'b00});
    exp_q.push_back({8'h44, 2'b00});
    rx_ready = 1'b1;
    wait_drain("overrun", 50);
    check("ovr_level_empty", 32'(rx_level), 32'd0);

    // Odd parity, corrupted parity bit on 0x01
`ifdef UART_CTRL_PARITY_EN
    exp_odd_q.push_back({8'h01, 2'b10});
`else
    exp_odd_q.push_back({8'h01, 2'b00});
`endif
    send_rx_frame(1'b1, 8'h01, 1'b1, 1'b1);
    drive(1'b1, 1'b1);
    wait_drain("odd_parity", 200);

    // Reset in the middle of a looped-back frame
    loop_en = 1'b1;
    send_tx(8'hC3);
    repeat (200) @(negedge clk);
    check("midrst_tx_busy", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx_high", 32'(tx), 32'd1);
    check("midrst_tx_ready", 32'(tx_ready), 32'd1);
    check("midrst_rx_idle", 32'(rx_busy), 32'd0);
    repeat (800) @(negedge clk);
    check("midrst_no_entry", 32'(rx_level), 32'd0);
    check("midrst_tx_stays_high", 32'(tx), 32'd1);
    loop_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
